// File: rtl/iob_axis_s_axi_m_write_burst.sv
// rtl/iob_axis_s_axi_m_write_burst.sv - AXI-Stream slave to AXI4 burst write master
//
// Moves w_length_i stream beats to memory starting at w_addr_i. The transfer is split into
// INCR bursts of at most BURST_MAX beats, and no burst crosses a 4 KB page. Only one burst
// is outstanding at a time.
//
// Optional feature macro: IOB_AXIS_S_AXI_M_WRITE_BURST_BRESP_CHECK_EN
//   defined   : a SLVERR/DECERR response sets w_error_o and ends the transfer early.
//   undefined : bresp/bid are ignored, w_error_o is tied 0, and every burst is issued.
//
// Ports
//   clk_i, cke_i, arst_n_i               clock, clock enable (all state holds when 0), async active-low reset
//   w_addr_i, w_length_i                 start byte address (aligned down to a beat), length in beats
//   w_start_transfer_i                   start pulse, sampled only in IDLE
//   w_busy_o, w_done_o, w_error_o        status: busy, one-cycle end pulse, sticky error
//   axis_in_data_i/valid_i, axis_in_ready_o   input stream
//   axi_aw*_o, axi_awready_i             AXI write-address channel
//   axi_w*_o, axi_wready_i               AXI write-data channel
//   axi_bresp_i, axi_bvalid_i, axi_bid_i, axi_bready_o   AXI write-response channel
module iob_axis_s_axi_m_write_burst #(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32,
    parameter int AXI_LEN_W  = 8,
    parameter int AXI_ID_W   = 1,
    parameter int LEN_W      = 16,
    parameter int BURST_MAX  = 16
) (
    input  logic                    clk_i,
    input  logic                    cke_i,
    input  logic                    arst_n_i,
    input  logic [AXI_ADDR_W-1:0]   w_addr_i,
    input  logic [LEN_W-1:0]        w_length_i,
    input  logic                    w_start_transfer_i,
    output logic                    w_busy_o,
    output logic                    w_done_o,
    output logic                    w_error_o,
    input  logic [AXI_DATA_W-1:0]   axis_in_data_i,
    input  logic                    axis_in_valid_i,
    output logic                    axis_in_ready_o,
    output logic [AXI_ADDR_W-1:0]   axi_awaddr_o,
    output logic                    axi_awvalid_o,
    input  logic                    axi_awready_i,
    output logic [AXI_LEN_W-1:0]    axi_awlen_o,
    output logic [2:0]              axi_awsize_o,
    output logic [1:0]              axi_awburst_o,
    output logic                    axi_awlock_o,
    output logic [3:0]              axi_awcache_o,
    output logic [3:0]              axi_awqos_o,
    output logic [AXI_ID_W-1:0]     axi_awid_o,
    output logic [AXI_DATA_W-1:0]   axi_wdata_o,
    output logic [AXI_DATA_W/8-1:0] axi_wstrb_o,
    output logic                    axi_wvalid_o,
    input  logic                    axi_wready_i,
    output logic                    axi_wlast_o,
    input  logic [1:0]              axi_bresp_i,
    input  logic                    axi_bvalid_i,
    input  logic [AXI_ID_W-1:0]     axi_bid_i,
    output logic                    axi_bready_o
);

    localparam int NB     = AXI_DATA_W / 8;
    localparam int NB_LOG = $clog2(NB);
    // Wide enough for the remaining count and for beats-to-page (up to 4096).
    localparam int CW     = (LEN_W > 14) ? LEN_W : 14;
    localparam logic [AXI_ADDR_W-1:0] ALIGN_MASK = ~AXI_ADDR_W'(NB - 1);

    typedef enum logic [1:0] {IDLE, CALC, BURST, RESP} state_t;

    state_t                  state, state_nxt;
    logic [AXI_ADDR_W-1:0]   addr;
    logic [LEN_W-1:0]        remaining;
    logic [CW-1:0]           burst;
    logic [AXI_LEN_W-1:0]    beat_cnt;
    logic                    aw_done;
    logic                    w_last_done;
    logic [AXI_ADDR_W-1:0]   awaddr_r;
    logic [AXI_LEN_W-1:0]    awlen_r;
    logic                    awvalid_r;
    logic [2:0]              awsize_r;
    logic [1:0]              awburst_r;
    logic [3:0]              awcache_r;
    logic                    done_r;

    logic                    start_ok;
    logic                    aw_hs, w_hs, w_last_hs, b_hs;
    logic                    last_burst;
    logic                    b_err;
    logic [12:0]             page_bytes;
    logic [CW-1:0]           beats_to_page;
    logic [CW-1:0]           burst_calc;
    logic                    in_burst;

    // bid is never checked; bresp only matters with the response check enabled.
    logic                    unused_b;
    assign unused_b = ^{axi_bid_i, axi_bresp_i};

    assign start_ok   = w_start_transfer_i & (w_length_i != '0);
    assign aw_hs      = axi_awvalid_o & axi_awready_i;
    assign w_hs       = axi_wvalid_o & axi_wready_i;
    assign w_last_hs  = w_hs & axi_wlast_o;
    assign b_hs       = axi_bvalid_i & axi_bready_o;
    // burst never exceeds remaining, so the truncating cast is lossless.
    assign last_burst = (remaining == LEN_W'(burst));

`ifdef IOB_AXIS_S_AXI_M_WRITE_BURST_BRESP_CHECK_EN
    logic error_r;
    assign b_err     = axi_bresp_i[1];
    assign w_error_o = error_r;
`else
    assign b_err     = 1'b0;
    assign w_error_o = 1'b0;
`endif

    // Burst length: smallest of remaining beats, BURST_MAX and beats left in the 4 KB page.
    always_comb begin
        page_bytes    = 13'h1000 - {1'b0, addr[11:0]};
        beats_to_page = CW'(page_bytes >> NB_LOG);
        burst_calc    = CW'(remaining);
        if (CW'(BURST_MAX) < burst_calc) burst_calc = CW'(BURST_MAX);
        if (beats_to_page < burst_calc)  burst_calc = beats_to_page;
    end

    // State register
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i)  state <= IDLE;
        else if (cke_i) state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start_ok) state_nxt = CALC;
            CALC:  state_nxt = BURST;
            // AW and the last W beat may complete in either order or together.
            BURST: if ((aw_done | aw_hs) & (w_last_done | w_last_hs)) state_nxt = RESP;
            RESP:  if (b_hs) state_nxt = (last_burst | b_err) ? IDLE : CALC;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: the W channel is a straight pass-through of the stream while a burst
    // still needs beats; once the last beat is taken the stream is stalled.
    always_comb begin
        in_burst        = (state == BURST) & cke_i & ~w_last_done;
        w_busy_o        = (state != IDLE);
        axi_wvalid_o    = in_burst & axis_in_valid_i;
        axis_in_ready_o = in_burst & axi_wready_i;
        axi_wdata_o     = in_burst ? axis_in_data_i : '0;
        axi_wstrb_o     = in_burst ? '1 : '0;
        axi_wlast_o     = in_burst & (beat_cnt == awlen_r);
        axi_bready_o    = (state == RESP) & cke_i;
        axi_awvalid_o   = awvalid_r & cke_i;
    end

    assign axi_awaddr_o  = awaddr_r;
    assign axi_awlen_o   = awlen_r;
    assign axi_awsize_o  = awsize_r;
    assign axi_awburst_o = awburst_r;
    assign axi_awcache_o = awcache_r;
    assign axi_awlock_o  = 1'b0;
    assign axi_awqos_o   = 4'd0;
    assign axi_awid_o    = '0;
    assign w_done_o      = done_r;

    // Datapath
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            addr        <= '0;
            remaining   <= '0;
            burst       <= '0;
            beat_cnt    <= '0;
            aw_done     <= 1'b0;
            w_last_done <= 1'b0;
            awaddr_r    <= '0;
            awlen_r     <= '0;
            awvalid_r   <= 1'b0;
            awsize_r    <= 3'd0;
            awburst_r   <= 2'd0;
            awcache_r   <= 4'd0;
            done_r      <= 1'b0;
`ifdef IOB_AXIS_S_AXI_M_WRITE_BURST_BRESP_CHECK_EN
            error_r     <= 1'b0;
`endif
        end else if (cke_i) begin
            done_r <= 1'b0;
            case (state)
                IDLE: if (start_ok) begin
                    addr      <= w_addr_i & ALIGN_MASK;
                    remaining <= w_length_i;
`ifdef IOB_AXIS_S_AXI_M_WRITE_BURST_BRESP_CHECK_EN
                    error_r   <= 1'b0;
`endif
                end
                CALC: begin
                    burst       <= burst_calc;
                    awaddr_r    <= addr;
                    awlen_r     <= AXI_LEN_W'(burst_calc - CW'(1));
                    awvalid_r   <= 1'b1;
                    awsize_r    <= 3'(NB_LOG);
                    awburst_r   <= 2'b01;
                    awcache_r   <= 4'b0010;
                    aw_done     <= 1'b0;
                    w_last_done <= 1'b0;
                    beat_cnt    <= '0;
                end
                BURST: begin
                    if (aw_hs) begin
                        awvalid_r <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (w_hs) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (axi_wlast_o) w_last_done <= 1'b1;
                    end
                end
                RESP: if (b_hs) begin
                    beat_cnt  <= '0;
                    addr      <= addr + (AXI_ADDR_W'(burst) << NB_LOG);
                    remaining <= remaining - LEN_W'(burst);
                    if (last_burst | b_err) done_r <= 1'b1;
`ifdef IOB_AXIS_S_AXI_M_WRITE_BURST_BRESP_CHECK_EN
                    if (b_err) error_r <= 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iob_axis_s_axi_m_write_burst.sv
// tb/tb_iob_axis_s_axi_m_write_burst.sv - directed self-checking bench for the AXIS to AXI burst writer
module tb_iob_axis_s_axi_m_write_burst;

    logic        clk = 1'b0;
    logic        cke, rst_n;
    logic [31:0] w_addr;
    logic [15:0] w_len;
    logic        start;
    logic        busy, done, error;
    logic [31:0] axis_data;
    logic        axis_valid, axis_ready;
    logic [31:0] awaddr;
    logic        awvalid, awready;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awlock;
    logic [3:0]  awcache, awqos;
    logic [0:0]  awid, bid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready, wlast;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    always #5 clk = ~clk;

    iob_axis_s_axi_m_write_burst dut (
        .clk_i(clk), .cke_i(cke), .arst_n_i(rst_n),
        .w_addr_i(w_addr), .w_length_i(w_len), .w_start_transfer_i(start),
        .w_busy_o(busy), .w_done_o(done), .w_error_o(error),
        .axis_in_data_i(axis_data), .axis_in_valid_i(axis_valid), .axis_in_ready_o(axis_ready),
        .axi_awaddr_o(awaddr), .axi_awvalid_o(awvalid), .axi_awready_i(awready),
        .axi_awlen_o(awlen), .axi_awsize_o(awsize), .axi_awburst_o(awburst),
        .axi_awlock_o(awlock), .axi_awcache_o(awcache), .axi_awqos_o(awqos), .axi_awid_o(awid),
        .axi_wdata_o(wdata), .axi_wstrb_o(wstrb), .axi_wvalid_o(wvalid),
        .axi_wready_i(wready), .axi_wlast_o(wlast),
        .axi_bresp_i(bresp), .axi_bvalid_i(bvalid), .axi_bid_i(bid), .axi_bready_o(bready)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave / source model state
    int          src_idx, src_total, aw_delay, aw_wait, err_burst;
    int          aw_cnt, wlast_cnt, b_cnt, done_cnt;
    bit          gaps;
    logic [31:0] data_base;
    bit          p_aw, p_w, p_b, p_axis;
    logic [31:0] aw_addr_q[$];
    int          aw_len_q[$];
    logic [31:0] w_data_q[$];
    bit          w_last_q[$];
    logic [2:0]  last_size;
    logic [1:0]  last_burst;
    logic [3:0]  last_cache, last_qos, last_strb;
    logic        last_lock;
    logic [0:0]  last_id;

    // Inputs change on the falling edge; handshakes are sampled 1 ns later and
    // take effect on the following rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (p_axis) src_idx++;
            if (p_b) begin b_cnt++; bvalid = 1'b0; end
            if (p_aw) aw_wait = 0;
            if (!(axis_valid && !p_axis))
                axis_valid = (src_idx < src_total) && (!gaps || $urandom_range(0, 2) != 0);
            axis_data = data_base + 32'(src_idx);
            wready = !gaps || ($urandom_range(0, 2) != 0);
            if (awvalid) aw_wait++;
            awready = awvalid && (aw_wait > aw_delay);
            if (!bvalid && b_cnt < wlast_cnt && b_cnt < aw_cnt) begin
                bvalid = 1'b1;
                bresp  = (b_cnt == err_burst) ? 2'b10 : 2'b00;
            end
            #1;
            p_aw   = awvalid && awready;
            p_w    = wvalid && wready;
            p_axis = axis_valid && axis_ready;
            p_b    = bvalid && bready;
            if (p_aw) begin
                aw_addr_q.push_back(awaddr);
                aw_len_q.push_back(int'(awlen));
                aw_cnt++;
                last_size = awsize; last_burst = awburst; last_cache = awcache;
                last_lock = awlock; last_qos = awqos; last_id = awid;
            end
            if (p_w) begin
                w_data_q.push_back(wdata);
                w_last_q.push_back(wlast);
                last_strb = wstrb;
                if (wlast) wlast_cnt++;
            end
            if (done) done_cnt++;
        end
    end

    task automatic clear_model();
        aw_addr_q.delete(); aw_len_q.delete(); w_data_q.delete(); w_last_q.delete();
        aw_cnt = 0; wlast_cnt = 0; b_cnt = 0; done_cnt = 0; src_idx = 0; aw_wait = 0;
        p_aw = 0; p_w = 0; p_b = 0; p_axis = 0;
        axis_valid = 1'b0; bvalid = 1'b0; awready = 1'b0;
    endtask

    task automatic launch(input logic [31:0] a, input int len, input logic [31:0] base,
                          input bit g, input int d, input int eb);
        @(negedge clk); #2;
        clear_model();
        src_total = len; data_base = base; gaps = g; aw_delay = d; err_burst = eb;
        w_addr = a; w_len = 16'(len); start = 1'b1;
        @(negedge clk); #2;
        start = 1'b0;
    endtask

    task automatic run_xfer(input string tag, input logic [31:0] a, input int len,
                            input logic [31:0] base, input bit g, input int d, input int eb);
        launch(a, len, base, g, d, eb);
        for (int i = 0; i < 3000 && done_cnt == 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check({tag, " done pulses"}, done_cnt, 1);
        check({tag, " busy after"}, busy, 0);
    endtask

    task automatic check_xfer(input string tag, input int n, input int ea[3], input int el[3],
                              input int beats, input logic [31:0] base);
        int cum;
        bit last_exp;
        check({tag, " aw count"}, aw_addr_q.size(), n);
        for (int i = 0; i < n && i < aw_addr_q.size(); i++) begin
            check($sformatf("%s awaddr%0d", tag, i), aw_addr_q[i], ea[i]);
            check($sformatf("%s awlen%0d", tag, i), aw_len_q[i], el[i]);
        end
        check({tag, " beats"}, w_data_q.size(), beats);
        for (int i = 0; i < w_data_q.size(); i++) begin
            check($sformatf("%s wdata%0d", tag, i), w_data_q[i], base + 32'(i));
            cum = 0; last_exp = 0;
            for (int k = 0; k < n; k++) begin
                cum += el[k] + 1;
                if (i == cum - 1) last_exp = 1;
            end
            check($sformatf("%s wlast%0d", tag, i), w_last_q[i], last_exp);
        end
    endtask

    initial begin
        int ea[3];
        int el[3];
        cke = 1'b1; rst_n = 1'b0; start = 1'b0; w_addr = '0; w_len = '0;
        bresp = 2'b00; bid = '0; src_total = 0; data_base = '0; gaps = 0;
        aw_delay = 0; err_burst = -1; axis_data = '0; wready = 1'b0;
        clear_model();
        repeat (3) @(negedge clk);
        #1;
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst error", error, 0);
        check("rst awvalid", awvalid, 0);
        check("rst awsize", awsize, 0);
        check("rst axis_ready", axis_ready, 0);
        check("rst bready", bready, 0);
        #1 rst_n = 1'b1;

        // Zero-length start is ignored
        launch(32'h0000_1000, 0, 32'h0, 0, 0, -1);
        repeat (5) @(negedge clk);
        check("len0 busy", busy, 0);
        check("len0 aw", aw_cnt, 0);
        check("len0 done", done_cnt, 0);

        // 1: single 16-beat burst
        run_xfer("t1", 32'h0000_1000, 16, 32'hA000_0000, 0, 0, -1);
        ea = '{32'h1000, 0, 0}; el = '{15, 0, 0};
        check_xfer("t1", 1, ea, el, 16, 32'hA000_0000);
        check("t1 awsize", last_size, 2);
        check("t1 awburst", last_burst, 1);
        check("t1 awcache", last_cache, 4'b0010);
        check("t1 awlock", last_lock, 0);
        check("t1 awqos", last_qos, 0);
        check("t1 awid", last_id, 0);
        check("t1 wstrb", last_strb, 4'hF);
        check("t1 error", error, 0);

        // 2: split at the 4 KB boundary
        run_xfer("t2", 32'h0000_0FF0, 8, 32'hB000_0000, 0, 0, -1);
        ea = '{32'h0FF0, 32'h1000, 0}; el = '{3, 3, 0};
        check_xfer("t2", 2, ea, el, 8, 32'hB000_0000);

        // 3: 40 beats in BURST_MAX chunks
        run_xfer("t3", 32'h0000_2000, 40, 32'hC000_0000, 0, 0, -1);
        ea = '{32'h2000, 32'h2040, 32'h2080}; el = '{15, 15, 7};
        check_xfer("t3", 3, ea, el, 40, 32'hC000_0000);

        // 4: unaligned start, stream/wready gaps, awready late by 10 cycles
        run_xfer("t4", 32'h0000_3FC3, 40, 32'hD000_0000, 1, 10, -1);
        ea = '{32'h3FC0, 32'h4000, 32'h4040}; el = '{15, 15, 7};
        check_xfer("t4", 3, ea, el, 40, 32'hD000_0000);

        // 5: error response on the first burst
        run_xfer("t5", 32'h0000_5000, 40, 32'hE000_0000, 0, 0, 0);
`ifdef IOB_AXIS_S_AXI_M_WRITE_BURST_BRESP_CHECK_EN
        ea = '{32'h5000, 0, 0}; el = '{15, 0, 0};
        check_xfer("t5", 1, ea, el, 16, 32'hE000_0000);
        check("t5 error", error, 1);
`else
        ea = '{32'h5000, 32'h5040, 32'h5080}; el = '{15, 15, 7};
        check_xfer("t5", 3, ea, el, 40, 32'hE000_0000);
        check("t5 error", error, 0);
`endif

        // 6: reset in the middle of a burst
        launch(32'h0000_6000, 16, 32'hF000_0000, 0, 10, -1);
        repeat (3) @(negedge clk);
        #2;
        check("t6 busy before", busy, 1);
        check("t6 wvalid before", wvalid, 1);
        rst_n = 1'b0;
        #1;
        check("t6 busy", busy, 0);
        check("t6 awvalid", awvalid, 0);
        check("t6 wvalid", wvalid, 0);
        check("t6 axis_ready", axis_ready, 0);
        check("t6 wstrb", wstrb, 0);
        check("t6 done", done, 0);
        @(negedge clk); #2;
        src_total = 0;
        clear_model();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t6 no done", done_cnt, 0);
        run_xfer("t6b", 32'h0000_7000, 16, 32'h1234_0000, 0, 0, -1);
        ea = '{32'h7000, 0, 0}; el = '{15, 0, 0};
        check_xfer("t6b", 1, ea, el, 16, 32'h1234_0000);
        check("t6b error", error, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
